// File: rtl/conv_pkg.sv
// Shared types and defaults for the streaming 2-D convolution engine.
// Build option: CONV_RELU_EN clamps negative results to zero.
package conv_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_KSIZE  = 3;
  localparam int DEF_IMG_W  = 224;
  localparam int DEF_IMG_H  = 224;
  localparam int DEF_ACC_W  = 23;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_KADDR_W = cw(DEF_KSIZE * DEF_KSIZE);
  localparam int DEF_COL_W   = cw(DEF_IMG_W);
  localparam int DEF_ROW_W   = cw(DEF_IMG_H);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN,
    DONE
  } conv_state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// Row storage for the window: KSIZE-1 rows of IMG_W pixels, indexed by column.
// Tap 0 is the incoming pixel, tap t is the pixel t rows above it.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int KSIZE  = DEF_KSIZE,
  parameter int DATA_W = DEF_DATA_W,
  localparam int COL_W = cw(IMG_W)
) (
  input  logic                    clk,
  input  logic                    shift_en,
  input  logic [COL_W-1:0]        col,
  input  logic [DATA_W-1:0]       din,
  output logic [KSIZE*DATA_W-1:0] taps
);

  logic [DATA_W-1:0] mem [KSIZE-1][IMG_W];

  always_comb begin
    taps[DATA_W-1:0] = din;
    for (int t = 1; t < KSIZE; t++)
      taps[t*DATA_W +: DATA_W] = mem[t-1][col];
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0][col] <= din;
      for (int r = 1; r < KSIZE-1; r++)
        mem[r][col] <= mem[r-1][col];
    end
  end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Raster-stream KSIZE x KSIZE convolution with a 2-stage MAC pipeline.
// Build option: CONV_RELU_EN clamps negative results to zero.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int KSIZE    = DEF_KSIZE,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int ACC_W    = DEF_ACC_W,
  localparam int KADDR_W = cw(KSIZE*KSIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               k_wr_en,
  input  logic [KADDR_W-1:0] k_wr_addr,
  input  logic [DATA_W-1:0]  k_wr_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [DATA_W-1:0]  pix_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int KK    = KSIZE * KSIZE;
  localparam int COL_W = cw(IMG_W);
  localparam int ROW_W = cw(IMG_H);
  localparam int PW    = 2 * DATA_W;

  conv_state_e state;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic signed [DATA_W-1:0] kern [KK];
  logic signed [DATA_W-1:0] win  [KK];
  logic signed [PW-1:0]     prod [KK];

  logic [KSIZE*DATA_W-1:0] taps;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] res_c;

  logic wv, wl, pv, pl;
  logic en, acc, eol, eof, in_win, first_win;

  // A held result freezes every stage, including pixel intake.
  assign en        = !(out_valid && !out_ready);
  assign pix_ready = en && (state == FILL || state == RUN);
  assign acc       = pix_valid && pix_ready;

  assign eol       = col == COL_W'(IMG_W-1);
  assign eof       = eol && row == ROW_W'(IMG_H-1);
  assign in_win    = col >= COL_W'(KSIZE-1) && row >= ROW_W'(KSIZE-1);
  assign first_win = col == COL_W'(KSIZE-1) && row == ROW_W'(KSIZE-1);

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .KSIZE (KSIZE),
    .DATA_W(DATA_W)
  ) u_lb (
    .clk     (clk),
    .shift_en(acc),
    .col     (col),
    .din     (pix_data),
    .taps    (taps)
  );

  always_ff @(posedge clk) begin
    if (state == IDLE && k_wr_en && int'(k_wr_addr) < KK)
      kern[k_wr_addr] <= k_wr_data;
  end

  // Window row 0 is the oldest image row; column KSIZE-1 is newest.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          if (c == KSIZE-1)
            win[r*KSIZE+c] <= taps[(KSIZE-1-r)*DATA_W +: DATA_W];
          else
            win[r*KSIZE+c] <= win[r*KSIZE+c+1];
    end
  end

  always_ff @(posedge clk) begin
    if (en)
      for (int i = 0; i < KK; i++)
        prod[i] <= PW'(win[i]) * PW'(kern[i]);
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < KK; i++)
      sum_c = sum_c + ACC_W'(prod[i]);
  end

`ifdef CONV_RELU_EN
  assign res_c = sum_c[ACC_W-1] ? '0 : sum_c;
`else
  assign res_c = sum_c;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wv        <= 1'b0;
      wl        <= 1'b0;
      pv        <= 1'b0;
      pl        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      if (en) begin
        wv        <= acc && in_win;
        wl        <= acc && eof;
        pv        <= wv;
        pl        <= wl;
        out_valid <= pv;
        out_last  <= pv && pl;
        if (pv)
          out_data <= res_c;
      end
      if (acc) begin
        col <= eol ? '0 : col + 1'b1;
        if (eol)
          row <= eof ? '0 : row + 1'b1;
      end
      unique case (state)
        IDLE:
          if (start) begin
            state <= FILL;
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        FILL:
          if (acc && eof)
            state <= DRAIN;
          else if (acc && first_win)
            state <= RUN;
        RUN:
          if (acc && eof)
            state <= DRAIN;
        DRAIN:
          if (out_valid && out_ready && out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        DONE:
          state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed and randomized frames against a plain-arithmetic convolution model.
// Define CONV_RELU_EN here too when the design is built with it.
module tb_conv2d_stream_engine;

  localparam int DW  = 9;
  localparam int KS  = 3;
  localparam int IW  = 5;
  localparam int IH  = 5;
  localparam int AW  = 23;
  localparam int NPX = IW * IH;
  localparam int OW  = IW - KS + 1;
  localparam int OH  = IH - KS + 1;
  localparam int NO  = OW * OH;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          k_wr_en;
  logic [3:0]    k_wr_addr;
  logic [DW-1:0] k_wr_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  int passed = 0;
  int total  = 0;
  int img    [NPX];
  int kern_m [KS*KS];
  int exp_q  [NO];

  conv2d_stream_engine #(
    .DATA_W(DW), .KSIZE(KS), .IMG_W(IW), .IMG_H(IH), .ACC_W(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .k_wr_en  (k_wr_en),
    .k_wr_addr(k_wr_addr),
    .k_wr_data(k_wr_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic compute_model();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < KS; i++)
          for (int j = 0; j < KS; j++)
            s += kern_m[i*KS+j] * img[(r+i)*IW + c + j];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_q[r*OW+c] = s;
      end
  endtask

  task automatic load_kernel();
    for (int i = 0; i < KS*KS; i++) begin
      @(negedge clk);
      k_wr_en   = 1'b1;
      k_wr_addr = 4'(i);
      k_wr_data = kern_m[i][DW-1:0];
    end
    @(negedge clk);
    k_wr_en = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int stall_at,
                           input bit kwrite);
    int  pidx, ridx, cyc, acc_cyc, first_cyc, stall_left;
    bit  got_done, stalled;
    pidx = 0; ridx = 0; cyc = 0; acc_cyc = -1; first_cyc = -1;
    stall_left = 0; got_done = 0; stalled = 0;
    compute_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, busy, 1);
    while (!got_done && cyc < 2000) begin
      if (out_valid && ridx == stall_at && !stalled) begin
        stalled = 1;
        stall_left = 10;
      end
      out_ready = (stall_left == 0);
      pix_valid = (pidx < NPX) && ($urandom_range(0, 3) != 0);
      pix_data  = (pidx < NPX) ? img[pidx][DW-1:0] : '0;
      k_wr_en   = kwrite && pidx == 8;
      k_wr_addr = 4'd4;
      k_wr_data = 9'd5;
      #1;
      if (stall_left > 0) begin
        check({tag, " held data"}, $signed(out_data), exp_q[ridx]);
        check({tag, " stall pix_ready"}, pix_ready, 0);
        stall_left--;
      end
      if (pix_valid && pix_ready) begin
        if (pidx == (KS-1)*IW + KS-1) acc_cyc = cyc;
        pidx++;
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && out_ready) begin
        check({tag, " data"}, $signed(out_data), exp_q[ridx]);
        check({tag, " last"}, out_last, ridx == NO-1);
        ridx++;
      end
      if (done) begin
        got_done = 1;
        check({tag, " busy at done"}, busy, 0);
        check({tag, " count"}, ridx, NO);
      end
      @(negedge clk);
      cyc++;
    end
    k_wr_en = 1'b0;
    out_ready = 1'b1;
    pix_valid = 1'b0;
    check({tag, " done seen"}, got_done, 1);
    check({tag, " latency"}, first_cyc - acc_cyc, 3);
    #1;
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle ready"}, pix_ready, 0);
  endtask

  task automatic set_kernel_fill(input int v);
    for (int i = 0; i < KS*KS; i++) kern_m[i] = v;
  endtask

  task automatic set_identity();
    set_kernel_fill(0);
    kern_m[(KS*KS)/2] = 1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < NPX; i++) img[i] = i;
  endtask

  task automatic set_img_fill(input int v);
    for (int i = 0; i < NPX; i++) img[i] = v;
  endtask

  task automatic set_img_rand();
    for (int i = 0; i < NPX; i++) img[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_last"}, out_last, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " pix_ready"}, pix_ready, 0);
    check({tag, " out_data"}, out_data, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; k_wr_en = 1'b0; k_wr_addr = '0;
    k_wr_data = '0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("reset");

    set_identity();
    load_kernel();
    set_ramp();
    run_frame("identity", -1, 0);
    check("identity first", exp_q[0], 6);

    set_kernel_fill(1);
    load_kernel();
    set_img_fill(127);
    run_frame("ones", -1, 0);

    set_kernel_fill(-1);
    load_kernel();
    set_img_fill(100);
    run_frame("neg", -1, 0);

    set_identity();
    load_kernel();
    set_ramp();
    run_frame("stall", 3, 0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 12; c++) begin
      pix_valid = 1'b1;
      pix_data  = img[n][DW-1:0];
      #1;
      if (pix_ready) n++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    check("partial fed", n, 12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    run_frame("after reset", -1, 0);

    run_frame("busy write", -1, 1);
    set_img_rand();
    run_frame("kernel kept", -1, 0);

    for (int i = 0; i < KS*KS; i++)
      kern_m[i] = int'($urandom_range(0, 511)) - 256;
    load_kernel();
    set_img_rand();
    run_frame("random", int'($urandom_range(0, NO-1)), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
